dct_2d_ctrl: RTL and testbench

Sequences one shared combinational 8-point 1D DCT datapath through a full 8x8 2D transform: row pass, then column pass.
- Row pass: accepts 8 pixel rows, one row per beat; drives each row through the shared transform; writes the results into an internal 8x8 transpose buffer.
- Column pass: reads the buffer column by column, drives each column back through the same transform, and presents registered column coefficients to the downstream quantizer stage.
- One shared transform instance, so there is no row/column overlap inside a block.

---
 rtl/dct_2d_ctrl_if.sv | 24 ++
 rtl/dct_2d_ctrl.sv | 143 ++++++++++++++
 tb/tb_dct_2d_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dct_2d_ctrl_if.sv
// Stream bundle for the 2D DCT controller: pixel rows in, column coefficients out.
interface dct_2d_ctrl_if #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 16
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0][PIX_W-1:0]  in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0][COEF_W-1:0] out_data;
  logic [2:0]             out_col;
  logic                   out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_col, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_col, out_last
  );
endinterface

// File: rtl/dct_2d_ctrl.sv
// Sequences one shared 8-point 1D DCT through a row pass into a transpose
// buffer, then a column pass into a registered output beat.
module dct_2d_ctrl #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  dct_2d_ctrl_if.slave           bus,
  output logic [7:0][COEF_W-1:0] dct_x_in_o,
  input  logic [7:0][COEF_W-1:0] dct_x_out_i,
  output logic                   dct_pass_o,
  output logic                   busy_o
);

  typedef enum logic {
    ST_ROW = 1'b0,
    ST_COL = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             row_cnt_q, row_cnt_d;
  logic [2:0]             col_cnt_q, col_cnt_d;
  logic [COEF_W-1:0]      buf_q [8][8];

  logic                   row_wr_s;
  logic                   col_load_s;
  logic                   in_ready_s;
  logic [7:0][COEF_W-1:0] x_in_s;

  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [2:0]             out_col_q, out_col_d;
  logic [7:0][COEF_W-1:0] out_data_q, out_data_d;

  // Pass sequencing and transform input selection.
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    col_cnt_d  = col_cnt_q;
    row_wr_s   = 1'b0;
    col_load_s = 1'b0;
    in_ready_s = 1'b0;
    x_in_s     = '0;
    case (state_q)
      ST_ROW: begin
        in_ready_s = 1'b1;
        for (int i = 0; i < 8; i++) begin
          x_in_s[i] = {{(COEF_W-PIX_W){1'b0}}, bus.in_data[i]};
        end
        if (bus.in_valid) begin
          row_wr_s = 1'b1;
          if (row_cnt_q == 3'd7) begin
            row_cnt_d = 3'd0;
            state_d   = ST_COL;
          end else begin
            row_cnt_d = row_cnt_q + 3'd1;
          end
        end else begin
          row_wr_s = 1'b0;
        end
      end
      ST_COL: begin
        // Column col_cnt of the transpose buffer feeds the transform.
        for (int k = 0; k < 8; k++) begin
          x_in_s[k] = buf_q[k][col_cnt_q];
        end
        if (!out_valid_q || bus.out_ready) begin
          col_load_s = 1'b1;
          if (col_cnt_q == 3'd7) begin
            col_cnt_d = 3'd0;
            state_d   = ST_ROW;
          end else begin
            col_cnt_d = col_cnt_q + 3'd1;
          end
        end else begin
          col_load_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_ROW;
      end
    endcase
  end

  // Output beat register: load a new column, drain, or hold under back-pressure.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_col_d   = out_col_q;
    out_data_d  = out_data_q;
    if (col_load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = dct_x_out_i;
      out_col_d   = col_cnt_q;
      out_last_d  = (col_cnt_q == 3'd7);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Control state and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ROW;
      row_cnt_q   <= 3'd0;
      col_cnt_q   <= 3'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_col_q   <= 3'd0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_col_q   <= out_col_d;
      out_data_q  <= out_data_d;
    end
  end

  // Transpose buffer: row results stored at full coefficient width, no reset needed.
  always_ff @(posedge clk) begin
    if (row_wr_s) begin
      for (int c = 0; c < 8; c++) begin
        buf_q[row_cnt_q][c] <= dct_x_out_i[c];
      end
    end
  end

  assign dct_x_in_o    = x_in_s;
  assign dct_pass_o    = (state_q == ST_COL);
  assign busy_o        = (state_q == ST_COL) || out_valid_q;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_dct_2d_ctrl.sv
// Scoreboard bench for dct_2d_ctrl; the external 1D transform is a
// sign-only (Hadamard) 8-point matrix so every expectation is exact.
module tb_dct_2d_ctrl;
  localparam int PIX_W  = 8;
  localparam int COEF_W = 16;

  typedef logic [7:0][PIX_W-1:0]  row_t;
  typedef logic [7:0][COEF_W-1:0] vec_t;
  typedef struct {
    vec_t       data;
    logic [2:0] col;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dct_2d_ctrl_if #(.PIX_W(PIX_W), .COEF_W(COEF_W)) bus ();
  vec_t dct_x_in;
  vec_t dct_x_out;
  logic dct_pass;
  logic busy;

  dct_2d_ctrl #(.PIX_W(PIX_W), .COEF_W(COEF_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dct_x_in_o  (dct_x_in),
    .dct_x_out_i (dct_x_out),
    .dct_pass_o  (dct_pass),
    .busy_o      (busy)
  );

  function automatic int hsign(int k, int n);
    return ($countones(k & n) % 2 == 1) ? -1 : 1;
  endfunction

  function automatic vec_t xform(vec_t x);
    vec_t r;
    int   acc;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int n = 0; n < 8; n++) acc += hsign(k, n) * int'($signed(x[n]));
      r[k] = COEF_W'(acc);
    end
    return r;
  endfunction

  assign dct_x_out = xform(dct_x_in);

  int    vectors    = 0;
  int    miscompares = 0;
  int    cyc        = 0;
  int    first_in   = -1;
  int    first_ov   = -1;
  int    last_t[$];
  bit    overlap_seen = 1'b0;
  row_t  model_rows[$];
  beat_t exp_q[$];
  row_t  row_q[$];
  int    in_pct = 100;
  int    rdy_pct = 100;
  bit    stall_arm = 1'b0;
  int    stall_cnt = 0;
  bit    stalling = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // 2D reference: rows through the matrix, then each column of the row results.
  function automatic void push_block();
    int    rr[8][8];
    int    y;
    beat_t b;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) begin
        rr[r][k] = 0;
        for (int n = 0; n < 8; n++) rr[r][k] += hsign(k, n) * int'(model_rows[r][n]);
      end
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 8; k++) begin
        y = 0;
        for (int r = 0; r < 8; r++) y += hsign(k, r) * rr[r][c];
        b.data[k] = COEF_W'(y);
      end
      b.col  = 3'(c);
      b.last = (c == 7);
      exp_q.push_back(b);
    end
    model_rows.delete();
  endfunction

  bit   pend = 1'b0;
  bit   after_last = 1'b0;
  vec_t pend_data;
  logic [2:0] pend_col;
  logic pend_last;

  // Monitor: feeds the model from accepted rows and scores every output beat.
  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (rst) begin
      model_rows.delete();
      exp_q.delete();
      pend       = 1'b0;
      after_last = 1'b0;
    end else begin
      if (after_last) chk("busy_after_last", busy, 1'b0);
      after_last = 1'b0;
      if (pend) begin
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_data", bus.out_data, pend_data);
        chk("hold_col", bus.out_col, pend_col);
        chk("hold_last", bus.out_last, pend_last);
      end
      if (bus.out_valid) begin
        chk("busy_while_valid", busy, 1'b1);
        if (first_ov < 0) first_ov = cyc;
        if (bus.out_col != 3'd7) begin
          chk("col_pass", dct_pass, 1'b1);
          chk("col_in_ready", bus.in_ready, 1'b0);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        chk("row_pass", dct_pass, 1'b0);
        if (first_in < 0) first_in = cyc;
        if (bus.out_valid && bus.out_col == 3'd7) overlap_seen = 1'b1;
        model_rows.push_back(bus.in_data);
        if (model_rows.size() == 8) push_block();
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          chk("out_data", bus.out_data, b.data);
          chk("out_col", bus.out_col, b.col);
          chk("out_last", bus.out_last, b.last);
        end
        if (bus.out_last) begin
          last_t.push_back(cyc);
          after_last = 1'b1;
        end
      end
      pend      = bus.out_valid && !bus.out_ready;
      pend_data = bus.out_data;
      pend_col  = bus.out_col;
      pend_last = bus.out_last;
    end
  end

  task automatic cycle();
    bit hs;
    bit arm_now;
    @(negedge clk);
    hs = bus.in_valid && bus.in_ready && !rst;
    if (stalling) begin
      chk("stall_valid", bus.out_valid, 1'b1);
      chk("stall_col", bus.out_col, 3'd3);
      chk("stall_in_ready", bus.in_ready, 1'b0);
    end
    arm_now = stall_arm && bus.out_valid && bus.out_ready && bus.out_col == 3'd2;
    @(posedge clk);
    #1;
    if (hs) void'(row_q.pop_front());
    if (arm_now) begin
      stall_arm = 1'b0;
      stall_cnt = 5;
    end
    bus.in_valid = (row_q.size() > 0) && ($urandom_range(0, 99) < in_pct);
    bus.in_data  = (row_q.size() > 0) ? row_q[0] : '0;
    if (stall_cnt > 0) begin
      bus.out_ready = 1'b0;
      stall_cnt--;
      stalling = 1'b1;
    end else begin
      stalling = 1'b0;
      bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  endtask

  task automatic run_until_idle(input int limit);
    int n = 0;
    while ((row_q.size() > 0 || exp_q.size() > 0 || stall_cnt > 0) && n < limit) begin
      cycle();
      n++;
    end
    if (n >= limit) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: still busy after %0d cycles, %0d beats pending", n, exp_q.size());
    end
    repeat (3) cycle();
  endtask

  task automatic push_const(input logic [7:0] v);
    row_t r;
    for (int i = 0; i < 8; i++) r[i] = v;
    repeat (8) row_q.push_back(r);
  endtask

  task automatic push_random();
    row_t r;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 5))
          0:       r[i] = 8'd255;
          1:       r[i] = 8'd0;
          default: r[i] = 8'($urandom_range(0, 255));
        endcase
      end
      row_q.push_back(r);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_out_last"}, bus.out_last, 1'b0);
    chk({tag, "_out_col"}, bus.out_col, 3'd0);
    chk({tag, "_out_data"}, bus.out_data, '0);
    chk({tag, "_dct_pass"}, dct_pass, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Streaming constant 128 block then constant 0 block.
    in_pct  = 100;
    rdy_pct = 100;
    push_const(8'd128);
    push_const(8'd0);
    run_until_idle(200);
    chk("first_latency", 128'(first_ov - first_in), 128'(9));
    chk("block_period", 128'((last_t.size() == 2) ? (last_t[1] - last_t[0]) : -1), 128'(16));
    chk("next_block_overlap", overlap_seen, 1'b1);

    // Random back-pressure with a forced 5-cycle hold on column 3.
    rdy_pct   = 50;
    stall_arm = 1'b1;
    push_random();
    push_random();
    run_until_idle(800);
    chk("stall_seen", stall_arm, 1'b0);

    // Random blocks with random valid/ready.
    in_pct  = 60;
    rdy_pct = 60;
    repeat (6) push_random();
    run_until_idle(3000);

    // Asynchronous reset mid-block after 4 accepted rows.
    in_pct  = 100;
    rdy_pct = 100;
    push_random();
    begin
      int n = 0;
      while (model_rows.size() < 4 && n < 100) begin
        cycle();
        n++;
      end
      chk("rows_before_reset", 128'(model_rows.size()), 128'(4));
    end
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    row_q.delete();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_random();
    run_until_idle(400);

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
